keypad_entry_ctrl: RTL

- Sequences the raw PS2 keyboard key-code stream into calculator operand entries.
- Watches the 8-bit `key_code_out` level (0 = no key) and debounces each press.
- Accumulates keypad digits into an NDIGITS-wide BCD operand.
- On an operator key, hands the operand plus operator to the downstream arithmetic/display block through a valid/ready handshake.

---
 rtl/keypad_pkg.sv | 59 +++++
 rtl/key_press_detect.sv | 55 +++++
 rtl/keypad_entry_ctrl.sv | 82 ++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// Shared keypad scan codes, operator encodings, key classes and entry FSM states.
package keypad_pkg;

    localparam logic [7:0] KP_0     = 8'h70;
    localparam logic [7:0] KP_1     = 8'h69;
    localparam logic [7:0] KP_2     = 8'h72;
    localparam logic [7:0] KP_3     = 8'h7A;
    localparam logic [7:0] KP_4     = 8'h6B;
    localparam logic [7:0] KP_5     = 8'h73;
    localparam logic [7:0] KP_6     = 8'h74;
    localparam logic [7:0] KP_7     = 8'h6C;
    localparam logic [7:0] KP_8     = 8'h75;
    localparam logic [7:0] KP_9     = 8'h7D;
    localparam logic [7:0] KP_PLUS  = 8'h79;
    localparam logic [7:0] KP_MINUS = 8'h7B;
    localparam logic [7:0] KP_STAR  = 8'h7C;
    localparam logic [7:0] KP_DOT   = 8'h71;

    localparam logic [1:0] OP_PLUS  = 2'd0;
    localparam logic [1:0] OP_MINUS = 2'd1;
    localparam logic [1:0] OP_MUL   = 2'd2;

    typedef enum logic [1:0] {DIGIT, OPER, CLEAR, IGNORE} key_class_e;

    typedef enum logic [1:0] {IDLE, DEBOUNCE, HELD, EMIT} state_e;

    typedef struct packed {
        key_class_e cls;
        logic [3:0] digit;
        logic [1:0] op;
    } key_decode_t;

    function automatic key_decode_t decode_key(input logic [7:0] code);
        key_decode_t d;
        // NOTE: every field gets a default first so no path leaves a field unassigned.
        d.cls   = IGNORE;
        d.digit = 4'd0;
        d.op    = OP_PLUS;
        case (code)
            KP_0:     begin d.cls = DIGIT; d.digit = 4'd0; end
            KP_1:     begin d.cls = DIGIT; d.digit = 4'd1; end
            KP_2:     begin d.cls = DIGIT; d.digit = 4'd2; end
            KP_3:     begin d.cls = DIGIT; d.digit = 4'd3; end
            KP_4:     begin d.cls = DIGIT; d.digit = 4'd4; end
            KP_5:     begin d.cls = DIGIT; d.digit = 4'd5; end
            KP_6:     begin d.cls = DIGIT; d.digit = 4'd6; end
            KP_7:     begin d.cls = DIGIT; d.digit = 4'd7; end
            KP_8:     begin d.cls = DIGIT; d.digit = 4'd8; end
            KP_9:     begin d.cls = DIGIT; d.digit = 4'd9; end
            KP_PLUS:  begin d.cls = OPER;  d.op = OP_PLUS;  end
            KP_MINUS: begin d.cls = OPER;  d.op = OP_MINUS; end
            KP_STAR:  begin d.cls = OPER;  d.op = OP_MUL;   end
            KP_DOT:   d.cls = CLEAR;
            default:  d.cls = IGNORE;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/key_press_detect.sv
// Debounces the key-code level and emits a one-cycle accept pulse per distinct press.
module key_press_detect
    import keypad_pkg::*;
#(
    parameter int STABLE_CYCLES = 2
) (
    input  logic       ck,
    input  logic       rst_n,
    input  logic [7:0] key_code,
    input  logic       freeze,
    output logic       accept,
    output logic [7:0] accept_code
);

    localparam logic [7:0] STABLE_CNT = 8'(STABLE_CYCLES);
    localparam bit         ONE_SHOT   = (STABLE_CYCLES == 1);

    state_e     state;
    logic [7:0] code;
    logic [7:0] cnt;
    logic [7:0] cnt_next;
    logic       key_down;
    logic       capture;
    logic       confirm;

    assign key_down = (key_code != 8'h00);
    assign cnt_next = cnt + 8'd1;
    assign capture  = key_down && ((state == IDLE) || (key_code != code));
    assign confirm  = (state == DEBOUNCE) && key_down && (key_code == code) && (cnt_next == STABLE_CNT);

    // Accept is combinational so the consumer registers its effect on the accepting edge itself.
    assign accept      = !freeze && ((capture && ONE_SHOT) || confirm);
    assign accept_code = key_code;

    always_ff @(posedge ck) begin
        // NOTE: non-blocking assignments keep every register sampling pre-edge values.
        if (!rst_n) begin
            state <= IDLE;
            code  <= 8'h00;
            cnt   <= 8'd0;
        end else if (!freeze) begin
            if (capture) begin
                code  <= key_code;
                cnt   <= 8'd1;
                state <= ONE_SHOT ? HELD : DEBOUNCE;
            end else if (!key_down) begin
                state <= IDLE;
            end else if (state == DEBOUNCE) begin
                cnt <= cnt_next;
                if (confirm) state <= HELD;
            end
        end
    end

endmodule

// File: rtl/keypad_entry_ctrl.sv
// Turns debounced keypad presses into a BCD operand and hands it off with an operator.
module keypad_entry_ctrl
    import keypad_pkg::*;
#(
    parameter  int NDIGITS       = 4,
    parameter  int STABLE_CYCLES = 2,
    localparam int CW            = $clog2(NDIGITS + 1)
) (
    input  logic                 ck,
    input  logic                 rst_n,
    input  logic [7:0]           key_code_in,
    output logic [4*NDIGITS-1:0] entry_bcd,
    output logic [1:0]           entry_op,
    output logic                 entry_valid,
    input  logic                 entry_ready,
    output logic [4*NDIGITS-1:0] live_bcd,
    output logic [CW-1:0]        digit_count,
    output logic                 overflow
);

    localparam int            W          = 4 * NDIGITS;
    localparam logic [CW-1:0] MAX_DIGITS = CW'(NDIGITS);

    logic        accept;
    logic [7:0]  accept_code;
    key_decode_t dec;
    logic [W-1:0] shifted;

    // The detector is frozen while an entry is pending, so key activity during EMIT is dropped.
    key_press_detect #(.STABLE_CYCLES(STABLE_CYCLES)) u_detect (
        .ck          (ck),
        .rst_n       (rst_n),
        .key_code    (key_code_in),
        .freeze      (entry_valid),
        .accept      (accept),
        .accept_code (accept_code)
    );

    assign dec     = decode_key(accept_code);
    assign shifted = (live_bcd << 4) | W'(dec.digit);

    always_ff @(posedge ck) begin
        if (!rst_n) begin
            entry_bcd   <= '0;
            entry_op    <= OP_PLUS;
            entry_valid <= 1'b0;
            live_bcd    <= '0;
            digit_count <= '0;
            overflow    <= 1'b0;
        end else if (entry_valid) begin
            if (entry_ready) begin
                entry_valid <= 1'b0;
                live_bcd    <= '0;
                digit_count <= '0;
                overflow    <= 1'b0;
            end
        end else if (accept) begin
            case (dec.cls)
                DIGIT: begin
                    if (digit_count < MAX_DIGITS) begin
                        live_bcd    <= shifted;
                        digit_count <= digit_count + CW'(1);
                    end else begin
                        overflow <= 1'b1;
                    end
                end
                OPER: begin
                    entry_bcd   <= live_bcd;
                    entry_op    <= dec.op;
                    entry_valid <= 1'b1;
                end
                CLEAR: begin
                    live_bcd    <= '0;
                    digit_count <= '0;
                    overflow    <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
